incr_arbiter: RTL and testbench

Round-robin scheduler that shares a single `incrementerN` datapath among M requesters. Each cycle it grants at most one pending request and captures that requester's operand plus one into a registered result slot. The result is presented with a valid/ready handshake and tagged with the requester ID. It sits between the address/counter-update clients and the one shared incrementer, replacing per-client incrementers.

---
 rtl/incr_pkg.sv | 21 ++
 rtl/incrementerN.sv | 15 +
 rtl/rr_pick.sv | 38 +++
 rtl/incr_arbiter.sv | 98 +++++++++
 tb/tb_incr_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/incr_pkg.sv
// incr_pkg: types, default sizes and pointer helper shared by the
// incr_arbiter slice.
//   slot_state_t : result slot state (EMPTY / FULL)
//   INCR_W       : default operand/result width
//   INCR_REQS    : default number of requesters
//   rr_next      : round-robin pointer advance with wrap at m
package incr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int INCR_W    = 5;
  localparam int INCR_REQS = 4;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned m);
    return (ptr + 1 >= m) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/incrementerN.sv
// incrementerN: the shared N-bit +1 datapath.
//   a     : operand
//   y     : a + 1 modulo 2^N
//   carry : carry out of the MSB, i.e. a was all-ones
module incrementerN #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y,
  output logic         carry
);

  assign {carry, y} = {1'b0, a} + {{N{1'b0}}, 1'b1};

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : per-requester request levels
//   ptr : index where the scan starts (highest priority this cycle)
//   en  : when low no grant is produced
//   gnt : one-hot grant, zero when en is low or nothing requests
//   idx : encoded grant index, zero when there is no grant
module rr_pick #(
  parameter  int M  = 4,
  localparam int IW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [M-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] k;

  // Scan upward from ptr, wrapping from M-1 back to 0; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < M; i++) begin
      if (32'(ptr) + i >= M) k = IW'(32'(ptr) + i - M);
      else                   k = IW'(32'(ptr) + i);
      if (en && !found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/incr_arbiter.sv
// incr_arbiter: shares one incrementerN among M requesters. Each cycle at
// most one pending request is granted round-robin and its operand + 1 is
// captured into a one-deep result slot drained by a valid/ready handshake.
//   clk_in        : clock, rising edge
//   rst_n_in      : asynchronous active-low reset
//   req_in        : per-requester request level, held until granted
//   op_in         : packed operands, requester k at [k*N +: N]
//   gnt_out       : combinational one-hot grant
//   res_out       : registered op + 1 (mod 2^N)
//   res_id_out    : requester index that produced res_out
//   wrap_out      : captured operand was all-ones (res_out is 0)
//   res_valid_out : result slot full
//   res_ready_in  : consumer accepts the result this cycle
//
// Slot FSM
//   state | meaning
//   EMPTY | no result held, res_valid_out = 0
//   FULL  | result held,    res_valid_out = 1
module incr_arbiter
  import incr_pkg::*;
#(
  parameter  int N  = INCR_W,
  parameter  int M  = INCR_REQS,
  localparam int IW = $clog2(M)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [M-1:0]    req_in,
  input  logic [M*N-1:0]  op_in,
  output logic [M-1:0]    gnt_out,
  output logic [N-1:0]    res_out,
  output logic [IW-1:0]   res_id_out,
  output logic            wrap_out,
  output logic            res_valid_out,
  input  logic            res_ready_in
);

  slot_state_t   state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          cap;
  logic [N-1:0]  op_sel;
  logic [N-1:0]  inc;
  logic          carry;

  assign res_valid_out = (state == FULL);

  // Capture whenever something requests and the slot is free or draining.
  assign cap = (|req_in) & (~res_valid_out | res_ready_in);

  // Grant is gated by reset so it reads zero while reset is held.
  rr_pick #(.M(M)) u_pick (
    .req (req_in),
    .ptr (ptr),
    .en  (cap & rst_n_in),
    .gnt (gnt_out),
    .idx (idx)
  );

  always_comb begin
    op_sel = '0;
    for (int k = 0; k < M; k++) begin
      if (idx == IW'(k)) op_sel = op_in[k*N +: N];
    end
  end

  incrementerN #(.N(N)) u_inc (
    .a     (op_sel),
    .y     (inc),
    .carry (carry)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= EMPTY;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cap)                               state_nxt = FULL;
    else if (res_valid_out && res_ready_in) state_nxt = EMPTY;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr        <= '0;
      res_out    <= '0;
      res_id_out <= '0;
      wrap_out   <= 1'b0;
    end else if (cap) begin
      ptr        <= IW'(rr_next(32'(idx), M));
      res_out    <= inc;
      res_id_out <= idx;
      wrap_out   <= carry;
    end
  end

endmodule

// File: tb/tb_incr_arbiter.sv
module tb_incr_arbiter;

  localparam int N  = 5;
  localparam int M  = 4;
  localparam int IW = 2;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [M-1:0]    req_in;
  logic [M*N-1:0]  op_in;
  logic [M-1:0]    gnt_out;
  logic [N-1:0]    res_out;
  logic [IW-1:0]   res_id_out;
  logic            wrap_out;
  logic            res_valid_out;
  logic            res_ready_in;

  incr_arbiter #(.N(N), .M(M)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_in        (req_in),
    .op_in         (op_in),
    .gnt_out       (gnt_out),
    .res_out       (res_out),
    .res_id_out    (res_id_out),
    .wrap_out      (wrap_out),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: pointer, slot occupancy and held result as plain ints.
  int m_ptr;
  int m_valid;
  int m_res;
  int m_id;
  int m_wrap;

  function automatic void m_reset();
    m_ptr = 0; m_valid = 0; m_res = 0; m_id = 0; m_wrap = 0;
  endfunction

  function automatic logic [M-1:0] model_gnt(input logic [M-1:0] req, input logic rdy);
    logic [M-1:0] g;
    g = '0;
    if (req != 0 && (m_valid == 0 || rdy)) begin
      for (int i = 0; i < M; i++) begin
        int k;
        k = (m_ptr + i) % M;
        if (req[k]) begin
          g[k] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  function automatic void model_update(input logic [M-1:0] g, input logic [M*N-1:0] ops,
                                       input logic rdy);
    if (g != 0) begin
      for (int k = 0; k < M; k++) begin
        if (g[k]) begin
          int op;
          op      = int'((ops >> (k*N)) & 20'h1F);
          m_res   = (op + 1) % 32;
          m_wrap  = (op == 31) ? 1 : 0;
          m_id    = k;
          m_ptr   = (k + 1) % M;
          m_valid = 1;
        end
      end
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check grant, step one edge, check slot.
  task automatic run_cycle(input logic [M-1:0] req, input logic [M*N-1:0] ops, input logic rdy,
                           input bit use_exp, input logic [M-1:0] eg, input int er,
                           input int ei, input int ew, input int ev, input string tag);
    logic [M-1:0] g;
    req_in = req; op_in = ops; res_ready_in = rdy;
    #2;
    g = model_gnt(req, rdy);
    if (!use_exp) eg = g;
    check({tag, " gnt"}, int'(gnt_out), int'(eg));
    @(posedge clk_in);
    model_update(g, ops, rdy);
    #1;
    if (!use_exp) begin
      er = m_res; ei = m_id; ew = m_wrap; ev = m_valid;
    end
    check({tag, " res"},   int'(res_out),       er);
    check({tag, " id"},    int'(res_id_out),    ei);
    check({tag, " wrap"},  int'(wrap_out),      ew);
    check({tag, " valid"}, int'(res_valid_out), ev);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gnt"},   int'(gnt_out),       0);
    check({tag, " res"},   int'(res_out),       0);
    check({tag, " id"},    int'(res_id_out),    0);
    check({tag, " wrap"},  int'(wrap_out),      0);
    check({tag, " valid"}, int'(res_valid_out), 0);
  endtask

  // Assert reset between edges with inputs still requesting, then release.
  task automatic reset_mid(input string tag);
    rst_n_in = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk_in);
    #1;
    check_zero({tag, " held"});
    rst_n_in = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [M-1:0]   req;
    logic [M*N-1:0] ops;
    logic           rdy;
    logic [M-1:0]   gnt;
    int             res;
    int             id;
    int             wrap;
    int             valid;
  } vec_t;

  localparam logic [M*N-1:0] OPS_A  = {5'd13, 5'd12, 5'd11, 5'd10};
  localparam logic [M*N-1:0] OPS_1F = {5'd0, 5'd0, 5'd0, 5'h1F};
  localparam logic [M*N-1:0] OPS_1E = {5'd0, 5'd0, 5'd0, 5'h1E};
  localparam logic [M*N-1:0] OPS_7  = {5'd0, 5'd7, 5'd0, 5'd0};

  vec_t tbl[$];

  initial begin
    // round robin, all requesting
    tbl.push_back(vec_t'{4'b1111, OPS_A, 1'b1, 4'b0001, 11, 0, 0, 1});
    tbl.push_back(vec_t'{4'b1111, OPS_A, 1'b1, 4'b0010, 12, 1, 0, 1});
    tbl.push_back(vec_t'{4'b1111, OPS_A, 1'b1, 4'b0100, 13, 2, 0, 1});
    tbl.push_back(vec_t'{4'b1111, OPS_A, 1'b1, 4'b1000, 14, 3, 0, 1});
    tbl.push_back(vec_t'{4'b1111, OPS_A, 1'b1, 4'b0001, 11, 0, 0, 1});
    // ptr = 1, idle requesters skipped
    tbl.push_back(vec_t'{4'b1001, OPS_A, 1'b1, 4'b1000, 14, 3, 0, 1});
    tbl.push_back(vec_t'{4'b1001, OPS_A, 1'b1, 4'b0001, 11, 0, 0, 1});
    tbl.push_back(vec_t'{4'b1001, OPS_A, 1'b1, 4'b1000, 14, 3, 0, 1});
    // wrap-around arithmetic
    tbl.push_back(vec_t'{4'b0001, OPS_1F, 1'b1, 4'b0001, 0, 0, 1, 1});
    tbl.push_back(vec_t'{4'b0001, OPS_1E, 1'b1, 4'b0001, 31, 0, 0, 1});
    // drain, then idle: data registers hold
    tbl.push_back(vec_t'{4'b0000, OPS_A, 1'b1, 4'b0000, 31, 0, 0, 0});
    tbl.push_back(vec_t'{4'b0000, OPS_A, 1'b0, 4'b0000, 31, 0, 0, 0});
    // empty slot captures even with ready low; full slot then blocks
    tbl.push_back(vec_t'{4'b0100, OPS_7, 1'b0, 4'b0100, 8, 2, 0, 1});
    tbl.push_back(vec_t'{4'b0100, OPS_7, 1'b0, 4'b0000, 8, 2, 0, 1});
    tbl.push_back(vec_t'{4'b0000, OPS_7, 1'b1, 4'b0000, 8, 2, 0, 0});

    req_in = 4'b1111; op_in = OPS_A; res_ready_in = 1'b1; rst_n_in = 1'b0;
    m_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_zero("por");
    rst_n_in = 1'b1;

    foreach (tbl[i])
      run_cycle(tbl[i].req, tbl[i].ops, tbl[i].rdy, 1'b1, tbl[i].gnt, tbl[i].res,
                tbl[i].id, tbl[i].wrap, tbl[i].valid, $sformatf("tbl%0d", i));

    // backpressure: ptr = 3, slot empty
    run_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, 1'b0, 1'b1, 4'b0001, 6, 0, 0, 1, "bp fill");
    for (int i = 0; i < 3; i++)
      run_cycle(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 1'b0, 1'b1, 4'b0000, 6, 0, 0, 1,
                $sformatf("bp hold%0d", i));
    run_cycle(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 1'b1, 1'b1, 4'b0010, 10, 1, 0, 1, "bp release");

    // reset mid-FULL with res_out = 7
    run_cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, 1'b1, 1'b1, 4'b0001, 7, 0, 0, 1, "rst prep");
    reset_mid("rst1");
    run_cycle(4'b0100, {5'd0, 5'd3, 5'd0, 5'd0}, 1'b1, 1'b1, 4'b0100, 4, 2, 0, 1, "rst1 first");

    // pointer is 3 here; reset must bring it back to 0
    reset_mid("rst2");
    run_cycle(4'b1111, OPS_A, 1'b1, 1'b1, 4'b0001, 11, 0, 0, 1, "rst2 ptr");

    for (int i = 0; i < 400; i++) begin
      logic [M-1:0]   r;
      logic [M*N-1:0] o;
      logic           y;
      r = M'($urandom_range(0, 15));
      o = (M*N)'($urandom);
      y = ($urandom_range(0, 3) != 0);
      run_cycle(r, o, y, 1'b0, '0, 0, 0, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
